uart_ram_loader: RTL and testbench



---
 rtl/uart_ram_loader_pkg.sv | 14 +
 rtl/loader_timeout.sv | 31 +++
 rtl/uart_ram_loader.sv | 137 +++++++++++++
 tb/tb_uart_ram_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ram_loader_pkg.sv
// Shared types and widths for the UART-to-RAM word loader.
// State encoding is fixed so firmware/debug taps can decode it directly.
package uart_ram_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_e;

  localparam int unsigned BYTE_IDX_W   = 2;
  localparam int unsigned WORD_COUNT_W = 16;

endpackage

// File: rtl/loader_timeout.sv
// Loadable down-counter that flags when TIMEOUT consecutive enabled cycles
// have elapsed since the last load.
module loader_timeout #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  // Reload on every load request; otherwise count down while enabled and stop at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= CW'(TIMEOUT);
    end else if (load_i) begin
      count_q <= CW'(TIMEOUT);
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - CW'(1);
    end
  end

  // Fires during the TIMEOUT-th idle cycle so the owner can act on the same edge.
  assign expired_o = en_i && (count_q == CW'(1));

endmodule

// File: rtl/uart_ram_loader.sv
// Packs serial bytes little-endian into 32-bit words and writes them to RAM
// port 2 at an auto-incrementing address whenever the arbiter grants the port.
module uart_ram_loader
  import uart_ram_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_in,
  input  logic                    set_addr,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic                    grant,
  output logic                    wEn2,
  output logic [ADDR_WIDTH-1:0]   addr2,
  output logic [31:0]             dataIn2,
  output logic                    busy,
  output logic [WORD_COUNT_W-1:0] word_count,
  output logic                    err
);

  state_e                  state_q;
  logic [BYTE_IDX_W-1:0]   idx_q;
  logic [7:0]              skid_q;
  logic                    skid_full_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             data_q;
  logic [WORD_COUNT_W-1:0] count_q;
  logic                    err_q;

  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [WORD_COUNT_W-1:0] count_d;
  logic                    tmo_load;
  logic                    tmo_en;
  logic                    tmo_expired;

  assign addr_d  = addr_q + ADDR_WIDTH'(1);
  assign count_d = (count_q == '1) ? count_q : count_q + WORD_COUNT_W'(1);

  // The idle timer only runs while a partial word is held and no byte arrives.
  assign tmo_load = (state_q != COLLECT) || byte_valid;
  assign tmo_en   = (state_q == COLLECT) && !byte_valid;

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmo_load),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else if (set_addr) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      skid_full_q <= 1'b0;
      addr_q      <= start_addr;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (byte_valid) begin
            data_q[7:0] <= byte_in;
            idx_q       <= BYTE_IDX_W'(1);
            state_q     <= COLLECT;
          end
        end
        COLLECT: begin
          if (byte_valid) begin
            data_q[{idx_q, 3'b000} +: 8] <= byte_in;
            if (idx_q == BYTE_IDX_W'(3)) begin
              idx_q   <= '0;
              state_q <= WRITE;
            end else begin
              idx_q <= idx_q + BYTE_IDX_W'(1);
            end
          end else if (tmo_expired) begin
            idx_q   <= '0;
            state_q <= IDLE;
            err_q   <= 1'b1;
          end
        end
        WRITE: begin
          // A byte that finds the skid slot occupied is lost, even if the write completes now.
          if (byte_valid && skid_full_q) begin
            err_q <= 1'b1;
          end
          if (grant) begin
            addr_q  <= addr_d;
            count_q <= count_d;
            if (skid_full_q) begin
              data_q[7:0] <= skid_q;
              skid_full_q <= 1'b0;
              idx_q       <= BYTE_IDX_W'(1);
              state_q     <= COLLECT;
            end else if (byte_valid) begin
              data_q[7:0] <= byte_in;
              idx_q       <= BYTE_IDX_W'(1);
              state_q     <= COLLECT;
            end else begin
              state_q <= IDLE;
            end
          end else if (byte_valid && !skid_full_q) begin
            skid_q      <= byte_in;
            skid_full_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Write strobe is combinational so an async reset drops it without a clock edge.
  assign wEn2       = (state_q == WRITE) && grant && !set_addr;
  assign addr2      = addr_q;
  assign dataIn2    = data_q;
  assign busy       = (state_q != IDLE) || skid_full_q;
  assign word_count = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Randomized and directed bench for uart_ram_loader against a byte-queue
// reference model of the loader's word assembly, skid, timeout and addressing.
module tb_uart_ram_loader;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        set_addr = 1'b0;
  logic [11:0] start_addr = '0;
  logic        grant = 1'b0;
  logic        wEn2;
  logic [11:0] addr2;
  logic [31:0] dataIn2;
  logic        busy;
  logic [15:0] word_count;
  logic        err;

  uart_ram_loader #(
    .ADDR_WIDTH (12),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .set_addr   (set_addr),
    .start_addr (start_addr),
    .grant      (grant),
    .wEn2       (wEn2),
    .addr2      (addr2),
    .dataIn2    (dataIn2),
    .busy       (busy),
    .word_count (word_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the partial word, the skid byte, and the pending word.
  logic [7:0]  held[$];
  logic [7:0]  skidQ[$];
  bit          pending;
  logic [31:0] pendWord;
  int          mAddr;
  int          mCount;
  bit          mErr;
  int          idle;

  int          checkCount = 0;
  int          failCount  = 0;
  int          wrCount    = 0;
  logic [31:0] lastWrAddr = '0;
  logic [31:0] lastWrData = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    held.delete();
    skidQ.delete();
    pending  = 1'b0;
    pendWord = '0;
    mAddr    = 0;
    mCount   = 0;
    mErr     = 1'b0;
    idle     = 0;
  endtask

  task automatic modelUpdate(input bit bv, input logic [7:0] b, input bit sa, input logic [11:0] sta, input bit g);
    if (sa) begin
      held.delete();
      skidQ.delete();
      pending = 1'b0;
      mAddr   = int'(sta);
      mCount  = 0;
      mErr    = 1'b0;
      idle    = 0;
    end else if (pending) begin
      if (bv) begin
        if (skidQ.size() != 0) mErr = 1'b1;
        else skidQ.push_back(b);
      end
      if (g) begin
        mAddr = (mAddr + 1) % 4096;
        if (mCount < 65535) mCount++;
        pending = 1'b0;
        idle    = 0;
        if (skidQ.size() != 0) held.push_back(skidQ.pop_front());
      end
    end else if (bv) begin
      held.push_back(b);
      idle = 0;
      if (held.size() == 4) begin
        pendWord = {held[3], held[2], held[1], held[0]};
        pending  = 1'b1;
        held.delete();
      end
    end else if (held.size() > 0) begin
      idle++;
      if (idle == TMO) begin
        held.delete();
        mErr = 1'b1;
        idle = 0;
      end
    end
  endtask

  // One clock of stimulus: drive, check at the falling edge, advance the model at the rising edge.
  task automatic applyStimulus(input bit bv, input logic [7:0] b, input bit sa, input logic [11:0] sta, input bit g);
    bit expW;
    byte_valid = bv;
    byte_in    = b;
    set_addr   = sa;
    start_addr = sta;
    grant      = g;
    @(negedge clk);
    expW = pending && g && !sa;
    checkOutput("wEn2", {31'b0, wEn2}, {31'b0, expW});
    checkOutput("addr2", {20'b0, addr2}, mAddr);
    checkOutput("word_count", {16'b0, word_count}, mCount);
    checkOutput("err", {31'b0, err}, {31'b0, mErr});
    checkOutput("busy", {31'b0, busy}, {31'b0, (held.size() > 0) || pending || (skidQ.size() > 0)});
    if (expW) checkOutput("dataIn2", dataIn2, pendWord);
    if (wEn2) begin
      lastWrAddr = {20'b0, addr2};
      lastWrData = dataIn2;
      wrCount++;
    end
    @(posedge clk);
    modelUpdate(bv, b, sa, sta, g);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit g);
    applyStimulus(1'b1, b, 1'b0, 12'h000, g);
  endtask

  task automatic idleCycle(input bit g);
    applyStimulus(1'b0, 8'h00, 1'b0, 12'h000, g);
  endtask

  task automatic loadAddr(input logic [11:0] a);
    applyStimulus(1'b0, 8'h00, 1'b1, a, 1'b0);
  endtask

  initial begin
    int wrBefore;
    int prob;
    modelReset();
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_wEn2", {31'b0, wEn2}, 32'h0);
    checkOutput("rst_addr2", {20'b0, addr2}, 32'h0);
    checkOutput("rst_dataIn2", dataIn2, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_word_count", {16'b0, word_count}, 32'h0);
    checkOutput("rst_err", {31'b0, err}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;

    // Addressing and packing
    loadAddr(12'h100);
    sendByte(8'h78, 1'b1);
    sendByte(8'h56, 1'b1);
    sendByte(8'h34, 1'b1);
    sendByte(8'h12, 1'b1);
    idleCycle(1'b1);
    checkOutput("pack_writes", wrCount, 32'd1);
    checkOutput("pack_addr", lastWrAddr, 32'h100);
    checkOutput("pack_data", lastWrData, 32'h12345678);
    checkOutput("pack_next_addr", {20'b0, addr2}, 32'h101);
    checkOutput("pack_count", {16'b0, word_count}, 32'd1);

    // Grant stall with skid byte
    sendByte(8'h11, 1'b0);
    sendByte(8'h22, 1'b0);
    sendByte(8'h33, 1'b0);
    sendByte(8'h44, 1'b0);
    sendByte(8'hAA, 1'b0);
    idleCycle(1'b0);
    checkOutput("stall_no_write", wrCount, 32'd1);
    checkOutput("stall_busy", {31'b0, busy}, 32'h1);
    idleCycle(1'b1);
    checkOutput("stall_data", lastWrData, 32'h44332211);
    sendByte(8'hBB, 1'b1);
    sendByte(8'hCC, 1'b1);
    sendByte(8'hDD, 1'b1);
    idleCycle(1'b1);
    checkOutput("skid_lsb_data", lastWrData, 32'hDDCCBBAA);
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h04, 1'b0);
    sendByte(8'h05, 1'b0);
    sendByte(8'h06, 1'b0);
    idleCycle(1'b0);
    checkOutput("overflow_err", {31'b0, err}, 32'h1);
    idleCycle(1'b1);

    // Address wrap
    loadAddr(12'hFFF);
    for (int i = 0; i < 4; i++) sendByte(8'(i + 1), 1'b1);
    idleCycle(1'b1);
    checkOutput("wrap_addr0", lastWrAddr, 32'hFFF);
    for (int i = 0; i < 4; i++) sendByte(8'(i + 5), 1'b1);
    idleCycle(1'b1);
    checkOutput("wrap_addr1", lastWrAddr, 32'h000);
    checkOutput("wrap_err", {31'b0, err}, 32'h0);

    // Timeout on a partial word
    loadAddr(12'h000);
    wrBefore = wrCount;
    sendByte(8'hE1, 1'b1);
    sendByte(8'hE2, 1'b1);
    repeat (TMO) idleCycle(1'b1);
    checkOutput("tmo_err", {31'b0, err}, 32'h1);
    checkOutput("tmo_busy", {31'b0, busy}, 32'h0);
    checkOutput("tmo_no_write", wrCount, wrBefore);
    sendByte(8'hA0, 1'b1);
    sendByte(8'hB1, 1'b1);
    sendByte(8'hC2, 1'b1);
    sendByte(8'hD3, 1'b1);
    idleCycle(1'b1);
    checkOutput("tmo_fresh_data", lastWrData, 32'hD3C2B1A0);
    checkOutput("tmo_fresh_addr", lastWrAddr, 32'h000);

    // set_addr abandons a pending write
    wrBefore = wrCount;
    sendByte(8'h10, 1'b0);
    sendByte(8'h20, 1'b0);
    sendByte(8'h30, 1'b0);
    sendByte(8'h40, 1'b0);
    idleCycle(1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 12'h040, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("abandon_no_write", wrCount, wrBefore);
    checkOutput("abandon_addr", {20'b0, addr2}, 32'h040);
    checkOutput("abandon_count", {16'b0, word_count}, 32'd0);
    checkOutput("abandon_err", {31'b0, err}, 32'h0);

    // Randomized traffic with varying byte density
    for (int blk = 0; blk < 30; blk++) begin
      case ($urandom_range(0, 3))
        0: prob = 3;
        1: prob = 15;
        2: prob = 50;
        default: prob = 90;
      endcase
      for (int c = 0; c < 100; c++) begin
        applyStimulus($urandom_range(0, 99) < prob, 8'($urandom),
                      $urandom_range(0, 299) == 0, 12'($urandom),
                      $urandom_range(0, 99) < 60);
      end
    end

    // Asynchronous reset while a write is being granted
    loadAddr(12'h123);
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h04, 1'b0);
    byte_valid = 1'b0;
    grant      = 1'b1;
    #2;
    checkOutput("pre_reset_wEn2", {31'b0, wEn2}, 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("async_wEn2", {31'b0, wEn2}, 32'h0);
    checkOutput("async_addr2", {20'b0, addr2}, 32'h0);
    checkOutput("async_dataIn2", dataIn2, 32'h0);
    checkOutput("async_busy", {31'b0, busy}, 32'h0);
    checkOutput("async_count", {16'b0, word_count}, 32'h0);
    checkOutput("async_err", {31'b0, err}, 32'h0);
    modelReset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    repeat (3) idleCycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
